exec_monitor: RTL and testbench
===============================

EXEC_MONITOR -- requirements
Module: exec_monitor

Interface
REQ-001 SHALL have parameter WORD_W, default 18, meaning width of PC, address and data words.
REQ-002 SHALL have parameter STALL_CYCLES, default 5, meaning consecutive unchanged-PC fetch cycles that declare program completion.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning run cycles before forced timeout.
REQ-004 SHALL have parameter TRACE_DEPTH, default 16 (power of two, >=2), meaning memory-write trace FIFO entries.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clock  in  1  system clock, all state updates on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle pulse, begin monitoring.
REQ-008 pc  in  WORD_W  CPU program counter.
REQ-009 fetch  in  1  high while the CPU is in its fetch state.
REQ-010 mem_write  in  1  CPU memory write strobe.
REQ-011 mem_addr, mem_wdata  in  WORD_W each  CPU write address and data.
REQ-012 trace_pop  in  1  consume current trace head.
REQ-013 running, done, timeout  out  1 each  monitor status, one-hot or all low.
REQ-014 pc_final  out  WORD_W  PC latched at done or timeout.
REQ-015 cycle_count  out  32  cycles spent in RUN.
REQ-016 trace_valid  out  1; trace_addr, trace_data  out  WORD_W; trace_overflow  out  1 sticky.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE, TIMEOUT; running/done/timeout are registered decodes of RUN/DONE/TIMEOUT.
REQ-018 IDLE->RUN on start; DONE or TIMEOUT->RUN on start (restart); start in RUN ignored.
REQ-019 On entry to RUN: cycle_count, stall counter and trace FIFO cleared, trace_overflow cleared, prev_pc loaded with current pc.
REQ-020 In RUN, cycle_count SHALL increment by 1 each cycle, saturating at 2^32-1.
REQ-021 In RUN, stall counter increments when fetch=1 and pc==prev_pc; clears when fetch=1 and pc!=prev_pc; holds when fetch=0; prev_pc updates on every fetch=1 cycle.
REQ-022 RUN->DONE on the cycle the stall counter would reach STALL_CYCLES; pc_final<=pc same edge.
REQ-023 RUN->TIMEOUT when cycle_count reaches TIMEOUT_CYCLES-1 and the edge increments it; pc_final<=pc.
REQ-024 Stall completion and timeout on same cycle: DONE wins.
REQ-025 DONE/TIMEOUT hold all outputs stable until start or reset; cycle_count frozen.
REQ-026 Trace push: mem_write=1 in RUN writes {mem_addr,mem_wdata}; mem_write outside RUN ignored.
REQ-027 Trace FIFO is show-ahead: trace_valid=!empty, trace_addr/trace_data show head combinationally from storage; trace_pop with trace_valid=1 removes head next edge; trace_pop when empty ignored.
REQ-028 Push when full and no pop: entry dropped, trace_overflow set; push and pop same cycle when full: both succeed, no overflow.
REQ-029 Trace FIFO readable in all states, including after DONE/TIMEOUT; pointers wrap modulo TRACE_DEPTH.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, running=done=timeout=0, pc_final=0, cycle_count=0, stall counter=0, prev_pc=0, FIFO empty, trace_valid=0, trace_overflow=0.
REQ-031 Reset asserted mid-RUN SHALL abort without latching pc_final; operation resumes only on a start after reset_n rises.

Structure
REQ-032 Shared package exec_mon_pkg SHALL hold the FSM state encoding (2-bit) and the 32-bit cycle-count width constant.
REQ-033 Trace storage SHALL be a sub-module trace_fifo (parameters WIDTH=2*WORD_W, DEPTH=TRACE_DEPTH) with push/pop/full/empty/overflow.

Verification
REQ-034 Reset, start, pc 0,1,2,3 then pc=3 on fetch for 5 consecutive fetch cycles -> done=1 on 5th, pc_final=3, running=0.
REQ-035 pc never stalls, TIMEOUT_CYCLES=20 -> timeout=1 with cycle_count=20, done=0.
REQ-036 5th stall cycle coincides with timeout cycle -> done=1, timeout=0.
REQ-037 TRACE_DEPTH=4, 6 writes (addr 0x10..0x15) no pops -> trace_overflow=1, pops return 0x10..0x13 then trace_valid=0; full with simultaneous push+pop -> no overflow.
REQ-038 reset_n low mid-RUN with 3 trace entries -> all outputs to reset values immediately; start after release resumes from cycle_count=0.
REQ-039 start in DONE -> RUN, cycle_count=0, trace empty, overflow cleared; fetch=0 cycles between stalled fetches do not reset stall counter.

Source files
------------

// File: rtl/exec_mon_pkg.sv
// Shared definitions for the execution monitor: FSM encoding and counter width.
package exec_mon_pkg;

    localparam int CYCLE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

endpackage

// File: rtl/exec_monitor_trace_fifo.sv
// Show-ahead FIFO holding CPU memory-write records; drops on full and flags overflow.
module trace_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/exec_monitor.sv
// Watches a CPU run: declares completion on a stalled PC, forces timeout, traces memory writes.
// state      | meaning
// ST_IDLE    | waiting for first start
// ST_RUN     | counting cycles, watching PC stall, tracing writes
// ST_DONE    | PC stalled STALL_CYCLES fetches; results frozen
// ST_TIMEOUT | TIMEOUT_CYCLES elapsed without completion; results frozen
module exec_monitor
    import exec_mon_pkg::*;
#(
    parameter int WORD_W         = 18,
    parameter int STALL_CYCLES   = 5,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TRACE_DEPTH    = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WORD_W-1:0]  pc,
    input  logic               fetch,
    input  logic               mem_write,
    input  logic [WORD_W-1:0]  mem_addr,
    input  logic [WORD_W-1:0]  mem_wdata,
    input  logic               trace_pop,
    output logic               running,
    output logic               done,
    output logic               timeout,
    output logic [WORD_W-1:0]  pc_final,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic               trace_valid,
    output logic [WORD_W-1:0]  trace_addr,
    output logic [WORD_W-1:0]  trace_data,
    output logic               trace_overflow
);

    localparam int                 STALL_W    = $clog2(STALL_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] CNT_MAX    = '1;
    localparam logic [CYCLE_W-1:0] TO_LAST    = CYCLE_W'(TIMEOUT_CYCLES - 1);

    state_t              state;
    logic [STALL_W-1:0]  stall_cnt;
    logic [WORD_W-1:0]   prev_pc;
    logic                enter_run;
    logic                same_pc;
    logic                stall_hit;
    logic                to_hit;
    logic                fifo_full;
    logic                fifo_empty;
    logic [2*WORD_W-1:0] fifo_dout;

    assign enter_run = start && (state != ST_RUN);
    assign same_pc   = fetch && (pc == prev_pc);
    assign stall_hit = same_pc && (stall_cnt == STALL_LAST);
    assign to_hit    = (cycle_count == TO_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            pc_final    <= '0;
            cycle_count <= '0;
            stall_cnt   <= '0;
            prev_pc     <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (cycle_count != CNT_MAX) cycle_count <= cycle_count + 1'b1;
                    if (fetch) begin
                        prev_pc   <= pc;
                        stall_cnt <= same_pc ? stall_cnt + 1'b1 : '0;
                    end
                    // Completion outranks a timeout landing on the same edge.
                    if (stall_hit) begin
                        state    <= ST_DONE;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        pc_final <= pc;
                    end else if (to_hit) begin
                        state    <= ST_TIMEOUT;
                        running  <= 1'b0;
                        timeout  <= 1'b1;
                        pc_final <= pc;
                    end
                end
                default: begin
                    if (enter_run) begin
                        state       <= ST_RUN;
                        running     <= 1'b1;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                        stall_cnt   <= '0;
                        prev_pc     <= pc;
                    end
                end
            endcase
        end
    end

    trace_fifo #(
        .WIDTH (2*WORD_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (enter_run),
        .push     (mem_write && (state == ST_RUN)),
        .din      ({mem_addr, mem_wdata}),
        .pop      (trace_pop),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (trace_overflow)
    );

    assign trace_valid = !fifo_empty;
    assign trace_addr  = fifo_dout[2*WORD_W-1:WORD_W];
    assign trace_data  = fifo_dout[WORD_W-1:0];

endmodule

// File: tb/tb_exec_monitor.sv
// Directed bench for exec_monitor: vector table for stall/restart, hand sequences for timeout, FIFO and reset.
module tb_exec_monitor;

    localparam int W = 18;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start, fetch, mem_write, trace_pop;
    logic [W-1:0]  pc, mem_addr, mem_wdata;
    logic          running, done, timeout, trace_valid, trace_overflow;
    logic [W-1:0]  pc_final, trace_addr, trace_data;
    logic [31:0]   cycle_count;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    exec_monitor #(
        .WORD_W         (W),
        .STALL_CYCLES   (5),
        .TIMEOUT_CYCLES (20),
        .TRACE_DEPTH    (4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .pc             (pc),
        .fetch          (fetch),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .trace_pop      (trace_pop),
        .running        (running),
        .done           (done),
        .timeout        (timeout),
        .pc_final       (pc_final),
        .cycle_count    (cycle_count),
        .trace_valid    (trace_valid),
        .trace_addr     (trace_addr),
        .trace_data     (trace_data),
        .trace_overflow (trace_overflow)
    );

    typedef struct {
        logic         start;
        logic         fetch;
        logic [W-1:0] pc;
        logic         wr;
        logic [W-1:0] addr;
        logic         pop;
        logic         e_run;
        logic         e_done;
        logic         e_to;
        logic [31:0]  e_cnt;
        logic [W-1:0] e_pcf;
        logic         e_valid;
        logic [W-1:0] e_head;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic s, input logic f, input int p, input logic wr,
                                input int a, input logic pp, input logic r, input logic d,
                                input logic t, input int c, input int pf, input logic v,
                                input int h);
        vec_t x;
        x.start = s;  x.fetch = f;  x.pc = W'(p);  x.wr = wr;  x.addr = W'(a);  x.pop = pp;
        x.e_run = r;  x.e_done = d; x.e_to = t;    x.e_cnt = 32'(c);
        x.e_pcf = W'(pf); x.e_valid = v; x.e_head = W'(h);
        return x;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic f, input int p, input logic wr,
                         input int a, input logic pp);
        start     = s;
        fetch     = f;
        pc        = W'(p);
        mem_write = wr;
        mem_addr  = W'(a);
        mem_wdata = W'(a) + W'(18'h100);
        trace_pop = pp;
    endtask

    task automatic chk_head(input string nm, input int a);
        chk({nm, "_valid"}, 32'(trace_valid), 32'd1);
        chk({nm, "_addr"}, 32'(trace_addr), 32'(a));
        chk({nm, "_data"}, 32'(trace_data), 32'(a + 'h100));
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        //               st f  pc wr addr pop  run dn to cnt pcf v head
        tbl[0]  = mk(1, 1, 0, 0, 0,    0,   1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 1, 'h10, 0,   1, 0, 0, 1, 0, 1, 'h10);
        tbl[2]  = mk(0, 1, 2, 1, 'h11, 0,   1, 0, 0, 2, 0, 1, 'h10);
        tbl[3]  = mk(0, 1, 3, 0, 0,    0,   1, 0, 0, 3, 0, 1, 'h10);
        tbl[4]  = mk(0, 1, 3, 0, 0,    0,   1, 0, 0, 4, 0, 1, 'h10);
        tbl[5]  = mk(0, 1, 3, 0, 0,    1,   1, 0, 0, 5, 0, 1, 'h11);
        tbl[6]  = mk(0, 1, 3, 0, 0,    0,   1, 0, 0, 6, 0, 1, 'h11);
        tbl[7]  = mk(0, 1, 3, 0, 0,    0,   1, 0, 0, 7, 0, 1, 'h11);
        tbl[8]  = mk(0, 1, 3, 0, 0,    0,   0, 1, 0, 8, 3, 1, 'h11);
        tbl[9]  = mk(0, 1, 7, 1, 'h55, 0,   0, 1, 0, 8, 3, 1, 'h11);
        tbl[10] = mk(0, 1, 7, 0, 0,    1,   0, 1, 0, 8, 3, 0, 0);
        tbl[11] = mk(1, 1, 5, 0, 0,    0,   1, 0, 0, 0, 3, 0, 0);
        tbl[12] = mk(0, 1, 5, 0, 0,    0,   1, 0, 0, 1, 3, 0, 0);
        tbl[13] = mk(0, 0, 9, 0, 0,    0,   1, 0, 0, 2, 3, 0, 0);
        tbl[14] = mk(0, 1, 5, 0, 0,    0,   1, 0, 0, 3, 3, 0, 0);
        tbl[15] = mk(0, 0, 9, 0, 0,    0,   1, 0, 0, 4, 3, 0, 0);
        tbl[16] = mk(0, 1, 5, 0, 0,    0,   1, 0, 0, 5, 3, 0, 0);
        tbl[17] = mk(1, 1, 5, 0, 0,    0,   1, 0, 0, 6, 3, 0, 0);
        tbl[18] = mk(0, 0, 9, 0, 0,    0,   1, 0, 0, 7, 3, 0, 0);
        tbl[19] = mk(0, 1, 5, 0, 0,    0,   0, 1, 0, 8, 5, 0, 0);

        #12;
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_count", cycle_count, 32'd0);
        chk("rst_pcf", 32'(pc_final), 32'd0);
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk("rst_ovf", 32'(trace_overflow), 32'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].start, tbl[i].fetch, int'(tbl[i].pc), tbl[i].wr,
                  int'(tbl[i].addr), tbl[i].pop);
            step();
            chk($sformatf("v%0d_running", i), 32'(running), 32'(tbl[i].e_run));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("v%0d_timeout", i), 32'(timeout), 32'(tbl[i].e_to));
            chk($sformatf("v%0d_count", i), cycle_count, tbl[i].e_cnt);
            chk($sformatf("v%0d_pcf", i), 32'(pc_final), 32'(tbl[i].e_pcf));
            chk($sformatf("v%0d_valid", i), 32'(trace_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid)
                chk($sformatf("v%0d_head", i), 32'(trace_addr), 32'(tbl[i].e_head));
        end

        // Timeout with a never-stalling PC.
        drive(1, 1, 0, 0, 0, 0);
        step();
        for (int i = 1; i < 20; i++) begin
            drive(0, 1, i, 0, 0, 0);
            step();
        end
        chk("to_pre_running", 32'(running), 32'd1);
        chk("to_pre_count", cycle_count, 32'd19);
        drive(0, 1, 20, 0, 0, 0);
        step();
        chk("to_timeout", 32'(timeout), 32'd1);
        chk("to_done", 32'(done), 32'd0);
        chk("to_running", 32'(running), 32'd0);
        chk("to_count", cycle_count, 32'd20);
        chk("to_pcf", 32'(pc_final), 32'd20);
        for (int i = 0; i < 3; i++) step();
        chk("to_hold_count", cycle_count, 32'd20);
        chk("to_hold_timeout", 32'(timeout), 32'd1);

        // Fifth stall lands on the timeout edge.
        drive(1, 1, 0, 0, 0, 0);
        step();
        for (int i = 1; i <= 15; i++) begin
            drive(0, 1, i, 0, 0, 0);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 15, 0, 0, 0);
            step();
        end
        chk("co_pre_done", 32'(done), 32'd0);
        chk("co_pre_count", cycle_count, 32'd19);
        step();
        chk("co_done", 32'(done), 32'd1);
        chk("co_timeout", 32'(timeout), 32'd0);
        chk("co_count", cycle_count, 32'd20);
        chk("co_pcf", 32'(pc_final), 32'd15);

        // FIFO overflow and drain, then timeout and restart.
        drive(1, 0, 7, 0, 0, 0);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 7, 1, 'h10 + i, 0);
            step();
            if (i == 3) chk("ff_full_no_ovf", 32'(trace_overflow), 32'd0);
        end
        chk("ff_ovf", 32'(trace_overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk_head($sformatf("ff_pop%0d", i), 'h10 + i);
            drive(0, 0, 7, 0, 0, 1);
            step();
        end
        chk("ff_drained", 32'(trace_valid), 32'd0);
        step();
        chk("ff_pop_empty", 32'(trace_valid), 32'd0);
        drive(0, 0, 7, 0, 0, 0);
        for (int k = 0; k < 30 && !timeout; k++) step();
        chk("ff_wait_timeout", 32'(timeout), 32'd1);
        chk("ff_ovf_sticky", 32'(trace_overflow), 32'd1);
        chk("ff_to_pcf", 32'(pc_final), 32'd7);

        drive(1, 0, 7, 0, 0, 0);
        step();
        chk("rs_running", 32'(running), 32'd1);
        chk("rs_count", cycle_count, 32'd0);
        chk("rs_ovf_clr", 32'(trace_overflow), 32'd0);
        chk("rs_empty", 32'(trace_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 7, 1, 'h20 + i, 0);
            step();
        end
        chk_head("rs_full", 'h20);
        drive(0, 0, 7, 1, 'h24, 1);
        step();
        chk("rs_pushpop_ovf", 32'(trace_overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk_head($sformatf("rs_pop%0d", i), 'h21 + i);
            drive(0, 0, 7, 0, 0, 1);
            step();
        end
        chk("rs_drained", 32'(trace_valid), 32'd0);
        chk("rs_count9", cycle_count, 32'd9);

        // Asynchronous reset mid-run with entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 7, 1, 'h30 + i, 0);
            step();
        end
        drive(0, 0, 7, 0, 0, 0);
        chk_head("ar_pre", 'h30);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_running", 32'(running), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_timeout", 32'(timeout), 32'd0);
        chk("ar_count", cycle_count, 32'd0);
        chk("ar_pcf", 32'(pc_final), 32'd0);
        chk("ar_valid", 32'(trace_valid), 32'd0);
        chk("ar_ovf", 32'(trace_overflow), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        step();
        chk("ar_idle", 32'(running), 32'd0);
        chk("ar_idle_count", cycle_count, 32'd0);
        drive(1, 0, 7, 0, 0, 0);
        step();
        drive(0, 0, 7, 0, 0, 0);
        chk("ar_restart_run", 32'(running), 32'd1);
        chk("ar_restart_count0", cycle_count, 32'd0);
        step();
        chk("ar_restart_count1", cycle_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
